// File: rtl/pipe_addsub_if.sv
// Handshake/data bundle for pipe_addsub: operand beat in, result beat out.
interface pipe_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [3:0]       flags;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, a, b, sel, cin, out_ready,
    input  in_ready, out_valid, sum, flags
  );

  // The arithmetic unit itself.
  modport slave (
    input  in_valid, a, b, sel, cin, out_ready,
    output in_ready, out_valid, sum, flags
  );
endinterface

// File: rtl/pipe_addsub.sv
// Carry-chained pipelined adder/subtractor. Each stage adds one CW-bit chunk and
// hands its carry to the next stage; the not-yet-added upper chunks ride along.
// A single global stall freezes every stage while the result is not taken.
module pipe_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic          clk,
  input logic          rst_n,
  pipe_addsub_if.slave bus
);
  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic stall;
  logic en;

  // Stage registers: valid, operands (upper chunks still pending), partial result, carry.
  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] bp_q;
  logic [STAGES-1:0][WIDTH-1:0] res_q;
  logic [3:0]                   flags_q;

  // What each stage sees on its input side (stage 0 sees the bus).
  logic [STAGES-1:0]            src_v;
  logic [STAGES-1:0]            src_c;
  logic [STAGES-1:0][WIDTH-1:0] src_a;
  logic [STAGES-1:0][WIDTH-1:0] src_bp;
  logic [STAGES-1:0][WIDTH-1:0] src_res;

  logic [STAGES-1:0][CW:0]      part;
  logic [STAGES-1:0][WIDTH-1:0] nxt_res;
  logic [STAGES-1:0]            nxt_c;
  logic [3:0]                   flags_d;
  logic [WIDTH-1:0]             fin;

  assign stall        = v_q[LAST] && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = en;

  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = res_q[LAST];
  assign bus.flags     = flags_q;

  // Route each stage's inputs: bus for stage 0, previous stage registers otherwise.
  always_comb begin
    src_v      = '0;
    src_c      = '0;
    src_a      = '0;
    src_bp     = '0;
    src_res    = '0;
    src_v[0]   = bus.in_valid;
    src_c[0]   = bus.cin;
    src_a[0]   = bus.a;
    src_bp[0]  = bus.sel ? ~bus.b : bus.b;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]   = v_q[k-1];
      src_c[k]   = c_q[k-1];
      src_a[k]   = a_q[k-1];
      src_bp[k]  = bp_q[k-1];
      src_res[k] = res_q[k-1];
    end
  end

  // Per-stage chunk adder: chunk k of A + chunk k of B' + incoming carry.
  always_comb begin
    part    = '0;
    nxt_res = '0;
    nxt_c   = '0;
    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_bp[k][k*CW +: CW]}
              + {{CW{1'b0}}, src_c[k]};
      nxt_res[k]                = src_res[k];
      nxt_res[k][k*CW +: CW]    = part[k][CW-1:0];
      nxt_c[k]                  = part[k][CW];
    end
  end

  // Flags for the beat completing in the final stage: {carry, overflow, zero, negative}.
  always_comb begin
    fin     = nxt_res[LAST];
    flags_d = {nxt_c[LAST],
               (src_a[LAST][WIDTH-1] == src_bp[LAST][WIDTH-1]) &&
               (fin[WIDTH-1] != src_a[LAST][WIDTH-1]),
               fin == '0,
               fin[WIDTH-1]};
  end

  // Pipeline advance; valid bits always move, data only loads behind a valid beat so
  // the outputs keep their last result across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q     <= '0;
      c_q     <= '0;
      a_q     <= '0;
      bp_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else if (en) begin
      v_q <= src_v;
      for (int k = 0; k < STAGES; k++) begin
        if (src_v[k]) begin
          a_q[k]   <= src_a[k];
          bp_q[k]  <= src_bp[k];
          res_q[k] <= nxt_res[k];
          c_q[k]   <= nxt_c[k];
        end
      end
      if (src_v[LAST]) begin
        flags_q <= flags_d;
      end
    end
  end
endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=32, STAGES=4) with a result scoreboard.
module tb_pipe_addsub;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_addsub_if #(.WIDTH(32)) bus ();

  pipe_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  flags;
    int          t;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic        cin;
    logic [31:0] sum;
    logic [3:0]  flags;
  } vec_t;

  exp_t exp_q[$];

  // Flat 33-bit reference: returns {carry, overflow, zero, negative, sum}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sel, input logic cin);
    logic [31:0] bp;
    logic [32:0] r;
    logic        ovf;
    bp  = sel ? ~b : b;
    r   = {1'b0, a} + {1'b0, bp} + {32'd0, cin};
    ovf = (a[31] == bp[31]) && (r[31] != a[31]);
    return {r[32], ovf, r[31:0] == 32'd0, r[31], r[31:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sel       = 1'b0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.sum !== 32'd0) begin bad++; $display("FAIL reset_sum: got %h want 0", bus.sum); end
    total++; if (bus.flags !== 4'd0) begin bad++; $display("FAIL reset_flags: got %b want 0000", bus.flags); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  // Spec vectors back to back; full expected values written out by hand.
  task automatic test_directed();
    vec_t        v [10];
    exp_t        e;
    int          i = 0;
    int          guard = 0;
    logic [31:0] last_sum;
    logic [3:0]  last_flags;
    v[0] = '{32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0020, 4'b0000};
    v[1] = '{32'h0000_0100, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_00F0, 4'b1000};
    v[2] = '{32'h0000_0000, 32'h0000_0010, 1'b1, 1'b1, 32'hFFFF_FFF0, 4'b0001};
    v[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1010};
    v[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101};
    v[5] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000D, 4'b0000};
    v[6] = '{32'h0000_0100, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_00EF, 4'b1000};
    v[7] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b1100};
    v[8] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 4'b1010};
    v[9] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 4'b0000};
    last_sum   = v[9].sum;
    last_flags = v[9].flags;
    while ((i < 10 || exp_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (i < 10);
      if (i < 10) begin
        bus.a   = v[i].a;
        bus.b   = v[i].b;
        bus.sel = v[i].sel;
        bus.cin = v[i].cin;
      end
      #1;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL directed_extra: got sum=%h, want no output", bus.sum);
        end else begin
          e = exp_q.pop_front();
          if (bus.sum !== e.sum || bus.flags !== e.flags || cyc - e.t != 4) begin
            bad++;
            $display("FAIL directed: got sum=%h flags=%b lat=%0d, want sum=%h flags=%b lat=4",
                     bus.sum, bus.flags, cyc - e.t, e.sum, e.flags);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back('{v[i].sum, v[i].flags, cyc, 1'b1});
        i++;
      end
      guard++;
    end
    bus.in_valid = 1'b0;
    total++; if (guard >= 200) begin bad++; $display("FAIL directed_timeout: got %0d pending, want 0", exp_q.size()); end
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.sum !== last_sum || bus.flags !== last_flags) begin
      bad++;
      $display("FAIL idle_hold: got v=%b sum=%h flags=%b, want v=0 sum=%h flags=%b",
               bus.out_valid, bus.sum, bus.flags, last_sum, last_flags);
    end
  endtask

  // Eight beats back to back; result side refuses for 3 cycles once data appears.
  task automatic test_back_to_back();
    exp_t        e;
    logic [35:0] m;
    int          i = 0;
    int          got = 0;
    int          guard = 0;
    int          stall_left = 3;
    bit          started = 1'b0;
    while ((i < 8 || exp_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      if (bus.out_valid) started = 1'b1;
      if (started && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      bus.in_valid = (i < 8);
      if (i < 8 && !(bus.in_valid && !bus.in_ready)) begin
        bus.a   = rnd_op();
        bus.b   = rnd_op();
        bus.sel = $urandom_range(0, 1) == 1;
        bus.cin = $urandom_range(0, 1) == 1;
      end
      #1;
      if (!bus.out_ready) begin
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        got++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra: got sum=%h, want no output", bus.sum);
        end else begin
          e = exp_q.pop_front();
          if (bus.sum !== e.sum || bus.flags !== e.flags) begin
            bad++;
            $display("FAIL b2b_order: got sum=%h flags=%b, want sum=%h flags=%b",
                     bus.sum, bus.flags, e.sum, e.flags);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        m = model(bus.a, bus.b, bus.sel, bus.cin);
        exp_q.push_back('{m[31:0], m[35:32], cyc, 1'b0});
        i++;
      end
      guard++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    total++; if (got != 8) begin bad++; $display("FAIL b2b_count: got %0d results want 8", got); end
    total++; if (stall_left != 0) begin bad++; $display("FAIL b2b_stall_seen: got %0d stall cycles left want 0", stall_left); end
  endtask

  // Random bubbles on both sides; in_ready must always track the stall condition.
  task automatic test_random();
    exp_t        e;
    logic [35:0] m;
    int          i = 0;
    int          guard = 0;
    while ((i < 40 || exp_q.size() != 0) && guard < 600) begin
      @(negedge clk);
      bus.in_valid  = (i < 40) && ($urandom_range(0, 9) < 7);
      bus.a         = rnd_op();
      bus.b         = rnd_op();
      bus.sel       = $urandom_range(0, 1) == 1;
      bus.cin       = $urandom_range(0, 1) == 1;
      bus.out_ready = $urandom_range(0, 9) < 7;
      #1;
      total++;
      if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
        bad++;
        $display("FAIL rand_in_ready: got %b want %b", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra: got sum=%h, want no output", bus.sum);
        end else begin
          e = exp_q.pop_front();
          if (bus.sum !== e.sum || bus.flags !== e.flags) begin
            bad++;
            $display("FAIL rand_result: got sum=%h flags=%b, want sum=%h flags=%b",
                     bus.sum, bus.flags, e.sum, e.flags);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        m = model(bus.a, bus.b, bus.sel, bus.cin);
        exp_q.push_back('{m[31:0], m[35:32], cyc, 1'b0});
        i++;
      end
      guard++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    total++; if (guard >= 600) begin bad++; $display("FAIL rand_timeout: got %0d pending want 0", exp_q.size()); end
  endtask

  // Reset with three beats in flight: they vanish, and a fresh beat runs normally.
  task automatic test_reset_flight();
    exp_t        e;
    logic [35:0] m;
    int          got = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a         = 32'h1000_0000 + n;
      bus.b         = 32'h0000_0100;
      bus.sel       = n[0];
      bus.cin       = 1'b1;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flight_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flight_in_ready: got %b want 1", bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.a        = 32'h0000_1234;
    bus.b        = 32'h0000_0234;
    bus.sel      = 1'b1;
    bus.cin      = 1'b1;
    m = model(bus.a, bus.b, bus.sel, bus.cin);
    exp_q.push_back('{m[31:0], m[35:32], cyc, 1'b1});
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid) begin
        total++;
        got++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL flight_stale: got sum=%h, want no output", bus.sum);
        end else begin
          e = exp_q.pop_front();
          if (bus.sum !== e.sum || bus.flags !== e.flags || cyc - e.t != 4) begin
            bad++;
            $display("FAIL flight_result: got sum=%h flags=%b lat=%0d, want sum=%h flags=%b lat=4",
                     bus.sum, bus.flags, cyc - e.t, e.sum, e.flags);
          end
        end
      end
    end
    total++; if (got != 1) begin bad++; $display("FAIL flight_count: got %0d results want 1", got); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline stages; WIDTH % STAGES == 0 and STAGES >= 1 required; chunk width CW = WIDTH/STAGES.
REQ-003 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1: unit accepts a beat this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port sel, input, 1: 0 = add (A+B+cin), 1 = subtract (A-B-~cin... see REQ-015).
REQ-010 SHALL have port cin, input, 1: carry-in for multi-word chaining.
REQ-011 SHALL have port out_valid, output, 1: result beat present.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-013 SHALL have port sum, output, WIDTH: result.
REQ-014 SHALL have port flags, output, 4: {carry, overflow, zero, negative}.

Function
REQ-015 Effective operation SHALL be sum = A + (sel ? ~B : B) + (sel ? cin : cin), with bench-level convention: add uses cin as carry-in; subtract passes cin=1 for plain A-B (cin=0 gives A-B-1, borrow chaining).
REQ-016 Input accepted when in_valid && in_ready; no other condition captures operands.
REQ-017 Stage k (0..STAGES-1) SHALL add chunk k of A and B' with the carry from stage k-1 (stage 0 uses cin), register CW result bits plus carry-out, and forward not-yet-added upper chunks unchanged.
REQ-018 Latency SHALL be exactly STAGES cycles from accept to out_valid with no stall; throughput one beat per cycle.
REQ-019 Each stage SHALL carry a valid bit; bubbles SHALL propagate and never raise out_valid.
REQ-020 Stall = out_valid && !out_ready; on stall all stage registers SHALL hold, and in_ready SHALL be 0.
REQ-021 in_ready SHALL equal !stall (combinational); no beat lost or duplicated across stall entry/exit.
REQ-022 sum, flags, out_valid SHALL be driven from final-stage registers only (no combinational input-to-output path).
REQ-023 carry SHALL be carry-out of bit WIDTH-1 (for subtract with cin=1: 1 = no borrow).
REQ-024 overflow SHALL be 1 iff sign(A) == sign(B') and sign(sum) != sign(A).
REQ-025 zero SHALL be 1 iff sum == 0; negative SHALL equal sum[WIDTH-1].
REQ-026 sel, cin and operand signs SHALL travel with their beat; changing sel mid-flight SHALL NOT affect beats already accepted.
REQ-027 When out_valid = 0, sum and flags SHALL hold their last values (don't-care to consumer).
REQ-028 STAGES = 1 SHALL degenerate to a single registered adder with identical handshake rules.

Reset
REQ-029 While rst_n = 0 at a rising edge, all stage valid bits, out_valid, sum and flags SHALL be cleared to 0.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 in the first cycle after rst_n returns high.
REQ-031 No output SHALL change on rst_n assertion except at a rising clk edge.

Verification (WIDTH=32, STAGES=4, out_ready=1 unless stated)
REQ-032 A=0x10, B=0x10, sel=0, cin=0 -> 4 cycles later out_valid=1, sum=0x20, flags=0000.
REQ-033 A=0x100, B=0x10, sel=1, cin=1 -> sum=0xF0, carry=1, overflow=0, zero=0, negative=0; and A=0x0, B=0x10, sel=1, cin=1 -> sum=0xFFFFFFF0, carry=0, negative=1.
REQ-034 A=0xFFFFFFFF, B=0x1, sel=0, cin=0 -> sum=0x0, carry=1, zero=1 (carry ripples through all four stages); A=0x7FFFFFFF, B=0x1 -> sum=0x80000000, overflow=1, negative=1.
REQ-035 Eight back-to-back beats, out_ready forced 0 for 3 cycles once out_valid=1 -> in_ready=0 during stall, all eight results emitted in order, none lost or duplicated.
REQ-036 rst_n=0 for one cycle with 3 beats in flight -> out_valid=0 next cycle, no stale result emitted, new beat accepted immediately after and returned after 4 cycles.
